// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared definitions for the data-memory arbiter: write-size
//             encodings (same as data_memory mem_write), port indices and
//             the alignment check helper.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    // Byte accesses are always aligned; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_req_if / dmem_mem_if
//  Purpose  : Bundles for the arbiter.
//             dmem_req_if : one requester port (request fields, combinational
//                           ready, registered rsp_valid/rdata/err).
//                           master = requester, slave = arbiter.
//             dmem_mem_if : single-port data_memory side.
//                           master = arbiter, slave = memory.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        wsize;
    logic              rd;
    logic              ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, wdata, wsize, rd,
                    input  ready, rsp_valid, rdata, err);
    modport slave  (input  req, addr, wdata, wsize, rd,
                    output ready, rsp_valid, rdata, err);
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        write;
    logic              read;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, wdata, write, read, input rdata);
    modport slave  (input  addr, wdata, write, read, output rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_rsp_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_rsp_reg
//  Purpose  : Per-port response register. Captures memory read data on a
//             granted aligned read and raises a one-cycle rsp_valid; raises a
//             one-cycle err on a granted misaligned access. rdata holds
//             between responses.
//  Ports    : clk, rst         clock / async active-high reset
//             capture          granted aligned read this cycle
//             err_set          granted misaligned access this cycle
//             mem_rdata        same-cycle read data from memory
//             rsp_valid/rdata/err  registered response outputs
//  Revision : 1.0  initial release
// ============================================================================
module dmem_rsp_reg
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              capture,
    input  wire logic              err_set,
    input  wire logic [DATA_W-1:0] mem_rdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   err
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            rsp_valid <= capture;
            err       <= err_set;
            if (capture) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-port data_memory between the core MEM stage
//             (p0, fixed priority) and the debug/loader DMA (p1). A
//             starvation counter hands p1 priority after STARVE_LIMIT refused
//             cycles. Misaligned accesses are accepted but never reach memory.
//  Ports    : clk, rst  clock / async active-high reset
//             p0, p1    requester ports (dmem_req_if.slave)
//             mem       data_memory port (dmem_mem_if.master)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dmem_req_if.slave   p0,
    dmem_req_if.slave   p1,
    dmem_mem_if.master  mem
);

    localparam logic [7:0] C_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_wait_cnt;

    logic w_p0_vld, w_p1_vld, w_p1_pri;
    logic w_gnt0, w_gnt1;
    logic w_p0_mis, w_p1_mis;
    logic w_p0_rd, w_p1_rd;

    assign w_p0_vld = p0.req && (p0.wsize != SZ_NONE || p0.rd);
    assign w_p1_vld = p1.req && (p1.wsize != SZ_NONE || p1.rd);

    // Pure reads are checked as word accesses.
    assign w_p0_mis = is_misaligned((p0.wsize != SZ_NONE) ? p0.wsize : SZ_WORD, p0.addr[1:0]);
    assign w_p1_mis = is_misaligned((p1.wsize != SZ_NONE) ? p1.wsize : SZ_WORD, p1.addr[1:0]);

    // A simultaneous write and read is treated as a write only.
    assign w_p0_rd = p0.rd && (p0.wsize == SZ_NONE);
    assign w_p1_rd = p1.rd && (p1.wsize == SZ_NONE);

    // Grants are gated by rst so nothing is accepted while reset is held.
    assign w_p1_pri = (r_wait_cnt == C_LIMIT) && w_p1_vld;
    assign w_gnt0   = !rst && w_p0_vld && !w_p1_pri;
    assign w_gnt1   = !rst && w_p1_vld && (!w_p0_vld || w_p1_pri);

    assign p0.ready = w_gnt0;
    assign p1.ready = w_gnt1;

    always_comb begin
        mem.addr  = '0;
        mem.wdata = '0;
        mem.write = SZ_NONE;
        mem.read  = 1'b0;
        if (w_gnt0) begin
            mem.addr  = p0.addr;
            mem.wdata = p0.wdata;
            if (!w_p0_mis) begin
                mem.write = p0.wsize;
                mem.read  = w_p0_rd;
            end
        end else if (w_gnt1) begin
            mem.addr  = p1.addr;
            mem.wdata = p1.wdata;
            if (!w_p1_mis) begin
                mem.write = p1.wsize;
                mem.read  = w_p1_rd;
            end
        end
    end

    // Counts refused p1 cycles; any p1 grant or idle p1 restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (w_p1_vld && !w_gnt1) begin
            if (r_wait_cnt != C_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp0 (
        .clk       (clk),
        .rst       (rst),
        .capture   (w_gnt0 && w_p0_rd && !w_p0_mis),
        .err_set   (w_gnt0 && w_p0_mis),
        .mem_rdata (mem.rdata),
        .rsp_valid (p0.rsp_valid),
        .rdata     (p0.rdata),
        .err       (p0.err)
    );

    dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp1 (
        .clk       (clk),
        .rst       (rst),
        .capture   (w_gnt1 && w_p1_rd && !w_p1_mis),
        .err_set   (w_gnt1 && w_p1_mis),
        .mem_rdata (mem.rdata),
        .rsp_valid (p1.rsp_valid),
        .rdata     (p1.rdata),
        .err       (p1.err)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a small
//             behavioural data_memory (same-cycle read, byte-lane writes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_req_if #(.ADDR_W(32), .DATA_W(32)) p0_if ();
    dmem_req_if #(.ADDR_W(32), .DATA_W(32)) p1_if ();
    dmem_mem_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if.slave),
        .p1  (p1_if.slave),
        .mem (mem_if.master)
    );

    // Behavioural data_memory: 64 words, combinational read.
    logic [31:0] mem_arr [0:63] = '{default: 32'h0};
    assign mem_if.rdata = mem_if.read ? mem_arr[mem_if.addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        case (mem_if.write)
            2'b01: mem_arr[mem_if.addr[7:2]][8*mem_if.addr[1:0] +: 8]   <= mem_if.wdata[7:0];
            2'b10: mem_arr[mem_if.addr[7:2]][16*mem_if.addr[1] +: 16]   <= mem_if.wdata[15:0];
            2'b11: mem_arr[mem_if.addr[7:2]]                            <= mem_if.wdata;
            default: ;
        endcase
    end

    task automatic drive0(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] wsize, input logic rd);
        p0_if.req = req; p0_if.addr = addr; p0_if.wdata = wdata; p0_if.wsize = wsize; p0_if.rd = rd;
    endtask

    task automatic drive1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] wsize, input logic rd);
        p1_if.req = req; p1_if.addr = addr; p1_if.wdata = wdata; p1_if.wsize = wsize; p1_if.rd = rd;
    endtask

    task automatic idle();
        drive0(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive1(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    // Every task starts 1 time unit after a rising edge; combinational
    // checks happen at the falling edge, registered ones just after the next rise.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        drive0(1'b1, 32'h0, 32'h1234_5678, 2'b11, 1'b0);
        drive1(1'b1, 32'h8, 32'h0, 2'b00, 1'b1);
        #1;
        checks++; if (p0_if.ready !== 1'b0) begin errors++; $display("FAIL rst_p0_ready got %b exp 0", p0_if.ready); end
        checks++; if (p1_if.ready !== 1'b0) begin errors++; $display("FAIL rst_p1_ready got %b exp 0", p1_if.ready); end
        checks++; if (mem_if.write !== 2'b00) begin errors++; $display("FAIL rst_mem_write got %b exp 00", mem_if.write); end
        checks++; if (mem_if.read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %b exp 0", mem_if.read); end
        checks++; if ({p0_if.rsp_valid, p0_if.err, p1_if.rsp_valid, p1_if.err} !== 4'b0000)
            begin errors++; $display("FAIL rst_flags got %b exp 0000", {p0_if.rsp_valid, p0_if.err, p1_if.rsp_valid, p1_if.err}); end
        checks++; if ({p0_if.rdata, p1_if.rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {p0_if.rdata, p1_if.rdata}); end
        checks++; if (dut.r_wait_cnt !== 8'd0) begin errors++; $display("FAIL rst_wait_cnt got %0d exp 0", dut.r_wait_cnt); end
        idle();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_write_read();
        drive0(1'b1, 32'h00, 32'hDEAD_BEEF, 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (p0_if.ready !== 1'b1) begin errors++; $display("FAIL wr_p0_ready got %b exp 1", p0_if.ready); end
        checks++; if (mem_if.write !== 2'b11) begin errors++; $display("FAIL wr_mem_write got %b exp 11", mem_if.write); end
        next_cycle();
        drive0(1'b1, 32'h00, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        checks++; if (mem_if.read !== 1'b1) begin errors++; $display("FAIL rd_mem_read got %b exp 1", mem_if.read); end
        next_cycle();
        idle();
        checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %b exp 1", p0_if.rsp_valid); end
        checks++; if (p0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", p0_if.rdata); end
        next_cycle();
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse got %b exp 0", p0_if.rsp_valid); end
        checks++; if (p0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata_hold got %h exp deadbeef", p0_if.rdata); end
    endtask

    task automatic test_contention();
        drive0(1'b1, 32'h00, 32'h0, 2'b00, 1'b1);
        drive1(1'b1, 32'h10, 32'h0, 2'b00, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (p0_if.ready !== (c != 4)) begin errors++; $display("FAIL cont_p0_ready[%0d] got %b exp %b", c, p0_if.ready, (c != 4)); end
            checks++; if (p1_if.ready !== (c == 4)) begin errors++; $display("FAIL cont_p1_ready[%0d] got %b exp %b", c, p1_if.ready, (c == 4)); end
            checks++; if (dut.r_wait_cnt !== ((c < 5) ? 8'(c) : 8'd0))
                begin errors++; $display("FAIL cont_wait_cnt[%0d] got %0d exp %0d", c, dut.r_wait_cnt, (c < 5) ? c : 0); end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_dma_read();
        drive1(1'b1, 32'h08, 32'h0000_BEEF, 2'b10, 1'b0);
        @(negedge clk);
        checks++; if (p1_if.ready !== 1'b1) begin errors++; $display("FAIL dma_wr_ready got %b exp 1", p1_if.ready); end
        checks++; if (mem_if.write !== 2'b10) begin errors++; $display("FAIL dma_mem_write got %b exp 10", mem_if.write); end
        next_cycle();
        drive1(1'b1, 32'h08, 32'h0, 2'b00, 1'b1);
        next_cycle();
        idle();
        checks++; if (p1_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL dma_rsp_valid got %b exp 1", p1_if.rsp_valid); end
        checks++; if (p1_if.rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL dma_rdata got %h exp 0000beef", p1_if.rdata); end
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL dma_p0_quiet got %b exp 0", p0_if.rsp_valid); end
        next_cycle();
    endtask

    task automatic test_misalign();
        drive0(1'b1, 32'h04, 32'h1122_3344, 2'b11, 1'b0);
        next_cycle();
        drive0(1'b1, 32'h06, 32'h5555_5555, 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (p0_if.ready !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", p0_if.ready); end
        checks++; if (mem_if.write !== 2'b00) begin errors++; $display("FAIL mis_mem_write got %b exp 00", mem_if.write); end
        next_cycle();
        drive0(1'b1, 32'h04, 32'h0, 2'b00, 1'b1);
        checks++; if (p0_if.err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", p0_if.err); end
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL mis_rsp_valid got %b exp 0", p0_if.rsp_valid); end
        next_cycle();
        idle();
        checks++; if (p0_if.err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got %b exp 0", p0_if.err); end
        checks++; if (p0_if.rdata !== 32'h1122_3344) begin errors++; $display("FAIL mis_readback got %h exp 11223344", p0_if.rdata); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, 32'h0C, 32'hCAFE_BABE, 2'b11, 1'b0);
        next_cycle();
        drive0(1'b1, 32'h00, 32'h0, 2'b00, 1'b1);
        next_cycle();
        drive0(1'b1, 32'h0C, 32'h0, 2'b00, 1'b1);
        checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %b exp 1", p0_if.rsp_valid); end
        checks++; if (p0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_data0 got %h exp deadbeef", p0_if.rdata); end
        next_cycle();
        idle();
        checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", p0_if.rsp_valid); end
        checks++; if (p0_if.rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL b2b_data1 got %h exp cafebabe", p0_if.rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        // p1 is refused in this cycle, so wait_cnt is 1 when reset hits.
        drive0(1'b1, 32'h00, 32'h0, 2'b00, 1'b1);
        drive1(1'b1, 32'h10, 32'h0, 2'b00, 1'b1);
        next_cycle();
        drive0(1'b1, 32'h00, 32'h0, 2'b11, 1'b0);
        checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b exp 1", p0_if.rsp_valid); end
        checks++; if (dut.r_wait_cnt !== 8'd1) begin errors++; $display("FAIL rm_pre_wait got %0d exp 1", dut.r_wait_cnt); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid got %b exp 0", p0_if.rsp_valid); end
        checks++; if ({p0_if.ready, p1_if.ready} !== 2'b00) begin errors++; $display("FAIL rm_ready got %b exp 00", {p0_if.ready, p1_if.ready}); end
        checks++; if (mem_if.write !== 2'b00) begin errors++; $display("FAIL rm_mem_write got %b exp 00", mem_if.write); end
        checks++; if (dut.r_wait_cnt !== 8'd0) begin errors++; $display("FAIL rm_wait_async got %0d exp 0", dut.r_wait_cnt); end
        next_cycle();
        checks++; if (mem_if.write !== 2'b00) begin errors++; $display("FAIL rm_mem_write_hold got %b exp 00", mem_if.write); end
        idle();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        checks++; if (dut.r_wait_cnt !== 8'd0) begin errors++; $display("FAIL rm_wait_after got %0d exp 0", dut.r_wait_cnt); end
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_after got %b exp 0", p0_if.rsp_valid); end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_contention();
        test_dma_read();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case a timing control never returns.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
